iter_comparator: RTL
====================

Name: iter_comparator

Overview:
- Parametrised multi-cycle successor to the single-flag comparator in the ALU path.
- Compares two WIDTH-bit operands chunk by chunk, MSB chunk first, with a start/busy/done handshake.
- Supports eight relations, signed and unsigned, so branch/slt logic can use wide operands without a long combinational compare chain.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle. NCHUNK = WIDTH/CHUNK, derived and must be ≥1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a compare; sampled only when busy=0.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- op  input  3  relation, captured with the operands: 000 EQ, 001 NE, 010 LT, 011 GE, 100 LTU, 101 GEU, 110 LE, 111 LEU.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result is updated.
- result  output  1  boolean result of the last completed compare.
- eq_flag  output  1  operands equal (last completed compare).
- lt_flag  output  1  A < B under the captured signedness (last completed compare).

Behaviour:
- Reset (async, reset_n=0): state=IDLE, busy=0, done=0, result=0, eq_flag=0, lt_flag=0, chunk index=NCHUNK-1.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → capture a, b, op; index=NCHUNK-1; go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy=1):
  - Each cycle compare chunk[index] of A and B as unsigned CHUNK-bit values.
  - Signed ops (EQ, NE, LT, GE, LE): the top chunk (index NCHUNK-1) has its MSB inverted in both operands before comparing. This gives two's-complement ordering; lower chunks are always unsigned.
  - Chunks differ → lt_flag=(chunkA<chunkB), eq_flag=0, go to DONE (early exit, see Optional Feature).
  - Chunks equal and index=0 → eq_flag=1, lt_flag=0, go to DONE.
  - Otherwise index decrements by 1.
  - start is ignored in RUN; operands and op are held internally, so input changes have no effect.
- DONE (busy=0):
  - done=1 for exactly this cycle; result is written on the RUN→DONE edge.
  - result: EQ=eq, NE=!eq, LT/LTU=lt, GE/GEU=!lt, LE/LEU=lt|eq.
  - start=1 in DONE → accepted immediately (capture, go to RUN). Otherwise go to IDLE.
- Latency: cycle 0 is the cycle start is sampled high. With k chunks examined (1..NCHUNK), done is high in cycle k+1.
- result, eq_flag and lt_flag hold their values until the next completion or reset.
- Reset mid-RUN aborts the compare: no done pulse, outputs return to reset values.
- NCHUNK=1: single RUN cycle; the sign inversion applies to that one chunk.

Optional Feature:
- Macro: ITER_CMP_EARLY_EXIT_EN.
- Defined: RUN ends at the first differing chunk, as described above (variable latency 2..NCHUNK+1).
- Undefined:
  - The first differing chunk's lt is latched internally and later chunks are ignored for the result.
  - RUN always lasts NCHUNK cycles; done is always in cycle NCHUNK+1.
  - result, eq_flag and lt_flag are bit-identical to the defined case.

Test Plan:
- Defaults WIDTH=32, CHUNK=8, early exit on, for all scenarios below.
- Assert reset_n=0 mid-cycle → busy=0, done=0, result=0, eq_flag=0, lt_flag=0 without waiting for a clock edge; hold 3 cycles, values unchanged.
- a=b=0x12345678, op=EQ, start in cycle 0 → busy in cycles 1-4, done=1 only in cycle 5, result=1, eq_flag=1, lt_flag=0.
- a=0xFFFFFFFF, b=0x00000001:
  - op=LT → done in cycle 2, result=1.
  - Repeat with op=LTU → result=0, lt_flag=0.
  - Repeat with op=GEU → result=1.
- a=0x80000000, b=0x7FFFFFFF, op=LE → result=1. Then a=0x00000105, b=0x00000106, op=LE → differs at chunk 0, done in cycle 5, result=1.
- Handshake:
  - Pulse start again in cycles 1-3 with different a/b → ignored, and the result matches the first operands.
  - start=1 in the DONE cycle → new compare begins next cycle with busy=1 and no IDLE cycle.
- reset_n=0 during cycle 2 of a 4-chunk compare → no done pulse; after release, state is IDLE and a fresh EQ compare of 0 vs 0 completes in cycle 5.
- Rerun all scenarios with ITER_CMP_EARLY_EXIT_EN undefined → identical results, with done always in cycle 5.

Source files
------------

// File: rtl/iter_comparator.sv
// iter_comparator: multi-cycle chunked comparator for wide operands.
// Compares A and B CHUNK bits per cycle, most significant chunk first, and
// reports one of eight signed/unsigned relations through a
// start/busy/done handshake.
// Optional feature macro: ITER_CMP_EARLY_EXIT_EN. When it is defined, RUN
// stops at the first differing chunk. Without it, RUN always walks every
// chunk and remembers the first difference it saw.
module iter_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             eq_flag,
    output logic             lt_flag
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b010;
    localparam logic [2:0] OP_GE  = 3'b011;
    localparam logic [2:0] OP_LTU = 3'b100;
    localparam logic [2:0] OP_GEU = 3'b101;
    localparam logic [2:0] OP_LE  = 3'b110;
    localparam logic [2:0] OP_LEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             result_q, result_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic             is_signed;
    logic             fin;
    logic             fin_eq;
    logic             fin_lt;

`ifndef ITER_CMP_EARLY_EXIT_EN
    logic seen_q, seen_d;
    logic seen_lt_q, seen_lt_d;
`endif

    // Map the relation code onto the final eq/lt outcome.
    function automatic logic rel_result(input logic [2:0] o, input logic e, input logic l);
        logic r;
        case (o)
            OP_EQ:          r = e;
            OP_NE:          r = ~e;
            OP_LT, OP_LTU:  r = l;
            OP_GE, OP_GEU:  r = ~l;
            OP_LE, OP_LEU:  r = l | e;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

    // Select the current chunk of both operands. For signed relations the
    // sign bit of the top chunk is flipped so that an unsigned compare of
    // that chunk follows two's-complement ordering.
    always_comb begin
        chunk_a   = '0;
        chunk_b   = '0;
        is_signed = ~((op_q == OP_LTU) || (op_q == OP_GEU) || (op_q == OP_LEU));
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                chunk_a = a_q[i*CHUNK +: CHUNK];
                chunk_b = b_q[i*CHUNK +: CHUNK];
            end
        end
        if (is_signed && (idx_q == IDX_TOP)) begin
            chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
            chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
        end
    end

    // Next-state logic: accept a request in IDLE or DONE, walk the chunks in
    // RUN, and write the flags and result on the RUN to DONE transition.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        fin      = 1'b0;
        fin_eq   = 1'b0;
        fin_lt   = 1'b0;
`ifndef ITER_CMP_EARLY_EXIT_EN
        seen_d    = seen_q;
        seen_lt_d = seen_lt_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    idx_d   = IDX_TOP;
                    state_d = ST_RUN;
`ifndef ITER_CMP_EARLY_EXIT_EN
                    seen_d    = 1'b0;
                    seen_lt_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
`ifdef ITER_CMP_EARLY_EXIT_EN
                if (chunk_a != chunk_b) begin
                    fin    = 1'b1;
                    fin_eq = 1'b0;
                    fin_lt = (chunk_a < chunk_b);
                end else if (idx_q == '0) begin
                    fin    = 1'b1;
                    fin_eq = 1'b1;
                    fin_lt = 1'b0;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
`else
                seen_d    = seen_q | (chunk_a != chunk_b);
                seen_lt_d = seen_q ? seen_lt_q : (chunk_a < chunk_b);
                if (idx_q == '0) begin
                    fin    = 1'b1;
                    fin_eq = ~seen_d;
                    fin_lt = seen_lt_d;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
`endif
                if (fin) begin
                    state_d  = ST_DONE;
                    eq_d     = fin_eq;
                    lt_d     = fin_lt;
                    result_d = rel_result(op_q, fin_eq, fin_lt);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any compare in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= IDX_TOP;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
        end
    end

`ifndef ITER_CMP_EARLY_EXIT_EN
    // First-difference memory used when every chunk is always visited.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_q    <= 1'b0;
            seen_lt_q <= 1'b0;
        end else begin
            seen_q    <= seen_d;
            seen_lt_q <= seen_lt_d;
        end
    end
`endif

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign result  = result_q;
    assign eq_flag = eq_q;
    assign lt_flag = lt_q;

endmodule
